// File: rtl/channel_collect_mux_pkg.sv
// rtl/channel_collect_mux_pkg.sv - shared constants, channel codes and FSM state for channel_collect_mux
// Package chmux_pkg:
//   NCH   - channel count (fixed at 4)
//   SEL_W - width of the channel select code carried with each word
//   CH0..CH3 - select codes matching the forward-path demux
//   state_t  - collector FSM state {IDLE, HOLD}
//   chan_code() - maps a 2-bit channel index to its select code
package chmux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] CH0 = 4'b0000;
  localparam logic [SEL_W-1:0] CH1 = 4'b0001;
  localparam logic [SEL_W-1:0] CH2 = 4'b0010;
  localparam logic [SEL_W-1:0] CH3 = 4'b0011;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] chan_code(input logic [1:0] idx);
    logic [SEL_W-1:0] code;
    case (idx)
      2'd0:    code = CH0;
      2'd1:    code = CH1;
      2'd2:    code = CH2;
      default: code = CH3;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/channel_collect_mux_if.sv
// rtl/channel_collect_mux_if.sv - channel-side and output-side handshake bundle for channel_collect_mux
// Signals:
//   in_valid[NCH], in_data[NCH*DW] (channel i at [i*DW +: DW]), in_ready[NCH]
//   out_valid, out_ready, out_data[DW], out_select[4]
//   out_parity (only when CHMUX_PARITY_EN is defined)
// Modports:
//   master - the collecting mux (drives in_ready and the output word)
//   slave  - the surrounding fabric (channel sources plus downstream sink)
interface channel_collect_mux_if
  import chmux_pkg::*;
#(
  parameter int DW = 8
);

  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [SEL_W-1:0]  out_select;
`ifdef CHMUX_PARITY_EN
  logic              out_parity;
`endif

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_data,
`ifdef CHMUX_PARITY_EN
    output out_parity,
`endif
    output out_select
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_data,
`ifdef CHMUX_PARITY_EN
    input  out_parity,
`endif
    input  out_select
  );

endinterface

// File: rtl/channel_collect_mux_rr_arbiter4.sv
// rtl/channel_collect_mux_rr_arbiter4.sv - combinational 4-way round-robin arbiter
// Ports:
//   req[3:0]   in  - per-channel request
//   ptr[1:0]   in  - highest-priority channel this cycle
//   en         in  - when low no grant is issued
//   grant[3:0] out - one-hot grant (all zero when none)
//   gidx[1:0]  out - index of the granted channel (0 when none)
//   any        out - a grant was issued
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] grant,
  output logic [1:0] gidx,
  output logic       any
);

  logic [1:0] idx;

  // Walk ptr, ptr+1, ... with 2-bit wraparound; first requester wins.
  always_comb begin
    grant = 4'b0000;
    gidx  = 2'd0;
    any   = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (en && !any && req[idx]) begin
        any        = 1'b1;
        gidx       = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_collect_mux.sv
// rtl/channel_collect_mux.sv - four-to-one round-robin collecting mux with registered, channel-tagged output
// Ports:
//   clk    in  - system clock, rising edge
//   rst_n  in  - synchronous active-low reset
//   enable in  - when low no new words are accepted; a held word still drains
//   bus    channel_collect_mux_if.master - channel inputs, in_ready, output word/handshake
// Optional feature: define CHMUX_PARITY_EN to add out_parity, the even parity over
// {out_select, out_data}, registered together with the word.
module channel_collect_mux
  import chmux_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  channel_collect_mux_if.master bus
);

  state_t           state;
  logic [1:0]       rr_ptr;
  logic             out_valid_q;
  logic [DW-1:0]    out_data_q;
  logic [SEL_W-1:0] out_select_q;

  logic             load_ok;
  logic [3:0]       grant;
  logic [1:0]       gidx;
  logic             any;
  logic [DW-1:0]    nxt_data;
  logic [SEL_W-1:0] nxt_select;

  // A new word may be taken when the output register is empty or being drained now.
  assign load_ok = enable & (~out_valid_q | bus.out_ready);

  // rst_n folds into the enable so in_ready stays low throughout reset.
  rr_arbiter4 u_arb (
    .req   (bus.in_valid),
    .ptr   (rr_ptr),
    .en    (load_ok & rst_n),
    .grant (grant),
    .gidx  (gidx),
    .any   (any)
  );

  assign bus.in_ready   = grant;
  assign nxt_data       = bus.in_data[int'(gidx)*DW +: DW];
  assign nxt_select     = chan_code(gidx);

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_select = out_select_q;

`ifdef CHMUX_PARITY_EN
  logic out_parity_q;
  assign bus.out_parity = out_parity_q;
`endif

  // any already implies load_ok, so in HOLD a grant only happens alongside out_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= 2'd0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_select_q <= CH0;
`ifdef CHMUX_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state        <= HOLD;
            out_valid_q  <= 1'b1;
            out_data_q   <= nxt_data;
            out_select_q <= nxt_select;
            rr_ptr       <= gidx + 2'd1;
`ifdef CHMUX_PARITY_EN
            out_parity_q <= ^{nxt_select, nxt_data};
`endif
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (any) begin
              out_valid_q  <= 1'b1;
              out_data_q   <= nxt_data;
              out_select_q <= nxt_select;
              rr_ptr       <= gidx + 2'd1;
`ifdef CHMUX_PARITY_EN
              out_parity_q <= ^{nxt_select, nxt_data};
`endif
            end else begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_collect_mux.sv
// tb/tb_channel_collect_mux.sv - self-checking bench for channel_collect_mux
module tb_channel_collect_mux;

  logic clk;
  logic rst_n;
  logic enable;
  int   total;
  int   bad;

  channel_collect_mux_if #(.DW(8)) bus ();

  channel_collect_mux #(.DW(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output register contents plus the round-robin pointer.
  int       m_ptr;
  bit       m_ov;
  bit [7:0] m_data;
  int       m_sel;
  bit       m_active;

  always @(negedge clk) begin
    bit       lok;
    int       win;
    bit [3:0] exp_rdy;
    if (m_active) begin
      check("m_out_valid", 32'(bus.out_valid), 32'(m_ov));
      check("m_out_data", 32'(bus.out_data), 32'(m_data));
      check("m_out_select", 32'(bus.out_select), 32'(m_sel));
`ifdef CHMUX_PARITY_EN
      check("m_out_parity", 32'(bus.out_parity), 32'($countones({m_sel[3:0], m_data}) % 2));
`endif
    end
    win = -1;
    lok = rst_n && enable && (!m_ov || bus.out_ready);
    if (lok) begin
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && bus.in_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      end
    end
    exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
    if (m_active || !rst_n) check("m_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (!rst_n) begin
      m_ptr = 0; m_ov = 0; m_data = 0; m_sel = 0; m_active = 1;
    end else if (m_active) begin
      if (win >= 0) begin
        m_data = bus.in_data[win*8 +: 8];
        m_sel  = win;
        m_ov   = 1;
        m_ptr  = (win + 1) % 4;
      end else if (m_ov && bus.out_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [7:0] d);
    bus.in_data[ch*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_active = 0;
    m_ptr = 0; m_ov = 0; m_data = 0; m_sel = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    bus.in_valid = 4'b1111;
    bus.in_data = 32'h13121110;
    bus.out_ready = 1'b0;

    // Reset with all channels requesting
    tick();
    tick();
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_select", 32'(bus.out_select), 32'h0);
    check("rst_out_data", 32'(bus.out_data), 32'h0);
    tick();

    // Single channel 2
    rst_n = 1'b1;
    bus.in_valid = 4'b0100;
    set_data(2, 8'hA5);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("single_in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check("single_in_ready_off", 32'(bus.in_ready), 32'h0);
    check("single_out_valid", 32'(bus.out_valid), 32'h1);
    check("single_out_data", 32'(bus.out_data), 32'hA5);
    check("single_out_select", 32'(bus.out_select), 32'h2);
    tick();

    // Round-robin from pointer 0
    do_reset();
    bus.in_data = 32'h13121110;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rr_out_valid", 32'(bus.out_valid), 32'h1);
      check("rr_out_select", 32'(bus.out_select), 32'(i % 4));
      check("rr_out_data", 32'(bus.out_data), 32'(8'h10 + i % 4));
    end
    tick();
    bus.in_valid = 4'b0000;
    tick();

    // Backpressure with 8'h3C held
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0001;
    set_data(0, 8'h3C);
    tick();
    set_data(0, 8'h3D);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_data", 32'(bus.out_data), 32'h3C);
      check("bp_hold_ready", 32'(bus.in_ready), 32'h0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_data", 32'(bus.out_data), 32'h3C);
    check("bp_release_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check("bp_next_data", 32'(bus.out_data), 32'h3D);
    check("bp_next_valid", 32'(bus.out_valid), 32'h1);
    tick();
    tick();

    // enable low: held word drains, no new grant until enable returns
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0001;
    set_data(0, 8'h55);
    tick();
    enable = 1'b0;
    set_data(0, 8'h66);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("en_low_ready", 32'(bus.in_ready), 32'h0);
      check("en_low_held", 32'(bus.out_data), 32'h55);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("en_low_drain_ready", 32'(bus.in_ready), 32'h0);
    tick();
    @(negedge clk);
    check("en_low_drained", 32'(bus.out_valid), 32'h0);
    tick();
    enable = 1'b1;
    @(negedge clk);
    check("en_high_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check("en_high_data", 32'(bus.out_data), 32'h66);
    check("en_high_select", 32'(bus.out_select), 32'h0);
    tick();

`ifdef CHMUX_PARITY_EN
    // Parity: channel 1 / 8'h01 -> 0, channel 0 / 8'h01 -> 1
    bus.in_valid = 4'b0010;
    set_data(1, 8'h01);
    tick();
    bus.in_valid = 4'b0001;
    set_data(0, 8'h01);
    @(negedge clk);
    check("par_ch1", 32'(bus.out_parity), 32'h0);
    tick();
    bus.in_valid = 4'b0000;
    @(negedge clk);
    check("par_ch0", 32'(bus.out_parity), 32'h1);
    tick();
`endif

    // Reset mid-operation discards the held word
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b1000;
    set_data(3, 8'h77);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(bus.in_ready), 32'h0);
    tick();
    @(negedge clk);
    check("midrst_valid", 32'(bus.out_valid), 32'h0);
    check("midrst_data", 32'(bus.out_data), 32'h0);
    rst_n = 1'b1;
    bus.in_valid = 4'b0000;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
